mem_port_arbiter: RTL and testbench

Sequencing controller for the single shared memory port of the pipelined ARM core. It arbitrates between the instruction-fetch requester (IF) and the data-memory requester (MEM stage), drives the 2:1 address/write-data multiplexer select, and times multi-cycle memory accesses with a wait-state counter. It returns read data and a one-cycle ready pulse to the winning requester; the pipeline freezes on "request && !ready".

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: IF and data requester handshakes plus the muxed memory bus.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              bus_sel;
  logic              bus_en;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  bus_sel, bus_en, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output bus_sel, bus_en, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer: alternating IF/data arbitration on contention, a
// WAIT_CYCLES-long access timed by a 4-bit down counter, then a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3    // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   mp
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              bus_sel_q, bus_sel_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_we_q, bus_we_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;   // 0 = IF won last, 1 = data won last
  logic              grant_dm;

  // On contention the requester that did not win last time gets the port.
  assign grant_dm = (mp.if_req && mp.dm_req) ? ~last_grant_q : mp.dm_req;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    bus_sel_d    = bus_sel_q;
    bus_en_d     = bus_en_q;
    bus_we_d     = bus_we_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (mp.if_req || mp.dm_req) begin
          state_d      = ACCESS;
          bus_sel_d    = grant_dm;
          last_grant_d = grant_dm;
          bus_en_d     = 1'b1;
          bus_we_d     = grant_dm & mp.dm_we;
          cnt_d        = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          bus_en_d   = 1'b0;
          bus_we_d   = 1'b0;
          if_ready_d = ~bus_sel_q;
          dm_ready_d = bus_sel_q;
          // Writes leave dm_rdata untouched; the other requester's word is held.
          if (!bus_sel_q)     if_rdata_d = mp.bus_rdata;
          else if (!bus_we_q) dm_rdata_d = mp.bus_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_sel_q    <= 1'b0;
      bus_en_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_sel_q    <= bus_sel_d;
      bus_en_q     <= bus_en_d;
      bus_we_q     <= bus_we_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mp.bus_sel   = bus_sel_q;
  assign mp.bus_en    = bus_en_q;
  assign mp.bus_we    = bus_we_q;
  assign mp.if_ready  = if_ready_q;
  assign mp.dm_ready  = dm_ready_q;
  assign mp.if_rdata  = if_rdata_q;
  assign mp.dm_rdata  = dm_rdata_q;
  assign mp.bus_addr  = bus_sel_q ? mp.dm_addr : mp.if_addr;
  assign mp.bus_wdata = bus_sel_q ? mp.dm_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a WAIT_CYCLES=3 instance against a cycle-timeline model
// (directed scenarios then random traffic) and a WAIT_CYCLES=1 instance with a fixed script.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut0 (
    .clk(clk), .rst(rst0), .mp(ifc0.slave)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .mp(ifc1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // Model: age = cycles since the IDLE cycle where the grant was sampled, -1 when idle.
  // ACCESS is age 1..W, the ready pulse is age W+1, and the next cycle is IDLE again.
  int          age = -1;
  bit          m_sel, m_last, m_we;
  logic [31:0] m_if_rd, m_dm_rd;

  bit          if_busy, dm_busy, if_drop, dm_drop;
  bit          rnd_mode;
  logic [31:0] rdata_fix;
  bit          w1_done;

  task automatic issue_if(input logic [31:0] addr);
    if_busy = 1'b1; if_drop = 1'b0;
    ifc0.if_addr = addr; ifc0.if_req = 1'b1;
  endtask

  task automatic issue_dm(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    dm_busy = 1'b1; dm_drop = 1'b0;
    ifc0.dm_we = we; ifc0.dm_addr = addr; ifc0.dm_wdata = wdata; ifc0.dm_req = 1'b1;
  endtask

  task automatic step();
    bit exp_en, exp_rdy;
    @(negedge clk);
    exp_en  = (age >= 1) && (age <= W);
    exp_rdy = (age == W + 1);
    check("bus_en",   ifc0.bus_en,   exp_en);
    check("bus_we",   ifc0.bus_we,   exp_en && m_we);
    check("bus_sel",  ifc0.bus_sel,  m_sel);
    check("if_ready", ifc0.if_ready, exp_rdy && !m_sel);
    check("dm_ready", ifc0.dm_ready, exp_rdy && m_sel);
    check("if_rdata", ifc0.if_rdata, m_if_rd);
    check("dm_rdata", ifc0.dm_rdata, m_dm_rd);
    if (exp_en) begin
      check("bus_addr",  ifc0.bus_addr,  m_sel ? ifc0.dm_addr : ifc0.if_addr);
      check("bus_wdata", ifc0.bus_wdata, m_sel ? ifc0.dm_wdata : 32'h0);
    end

    @(posedge clk);
    if (rst0) begin
      age = -1; m_sel = 1'b0; m_last = 1'b0; m_we = 1'b0;
      m_if_rd = '0; m_dm_rd = '0;
      if (if_drop) begin if_busy = 1'b0; if_drop = 1'b0; end
      if (dm_drop) begin dm_busy = 1'b0; dm_drop = 1'b0; end
    end else if (age == -1) begin
      if (ifc0.if_req || ifc0.dm_req) begin
        m_sel  = (ifc0.if_req && ifc0.dm_req) ? !m_last : ifc0.dm_req;
        m_last = m_sel;
        m_we   = m_sel && ifc0.dm_we;
        age    = 1;
      end
    end else if (age < W) begin
      age++;
    end else if (age == W) begin
      if (!m_sel)     m_if_rd = ifc0.bus_rdata;
      else if (!m_we) m_dm_rd = ifc0.bus_rdata;
      age++;
    end else begin
      if (m_sel) begin dm_busy = 1'b0; dm_drop = 1'b0; end
      else       begin if_busy = 1'b0; if_drop = 1'b0; end
      age = -1;
    end

    #1;
    if (rnd_mode) begin
      if (age >= 1 && age < W && $urandom_range(0, 7) == 0) begin
        if (m_sel) dm_drop = dm_busy; else if_drop = if_busy;
      end
      if (!if_busy && $urandom_range(0, 1) == 1) begin
        if_busy = 1'b1;
        ifc0.if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dm_busy && $urandom_range(0, 1) == 1) begin
        dm_busy = 1'b1;
        ifc0.dm_we    = $urandom_range(0, 1) == 1;
        ifc0.dm_addr  = $urandom() & 32'hFFFF_FFFC;
        ifc0.dm_wdata = $urandom();
      end
      ifc0.bus_rdata = $urandom();
      rst0 = ($urandom_range(0, 299) == 0);
    end else begin
      ifc0.bus_rdata = rdata_fix;
    end
    ifc0.if_req = if_busy && !if_drop;
    ifc0.dm_req = dm_busy && !dm_drop;
  endtask

  initial begin
    m_if_rd = '0; m_dm_rd = '0; rdata_fix = '0;
    ifc0.if_req = 0; ifc0.if_addr = '0; ifc0.dm_req = 0; ifc0.dm_we = 0;
    ifc0.dm_addr = '0; ifc0.dm_wdata = '0; ifc0.bus_rdata = '0;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;

    step();                                      // reset state, idle
    issue_if(32'h100);
    rdata_fix = 32'hE3A0_1005;
    repeat (7) step();

    issue_if(32'h104);                           // contention: data wins first
    issue_dm(1'b0, 32'h200, 32'h0);
    rdata_fix = 32'hCAFE_F00D;
    repeat (12) step();

    issue_dm(1'b1, 32'h40, 32'h1234_5678);       // write must not touch dm_rdata
    rdata_fix = 32'hDEAD_BEEF;
    repeat (6) step();

    issue_if(32'h300);                           // reset in cycle 2 of an IF access
    rdata_fix = 32'h1111_2222;
    step(); step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    repeat (8) step();

    issue_if(32'h400);                           // both held: alternating grants
    issue_dm(1'b0, 32'h500, 32'h0);
    rdata_fix = 32'h0F0F_0F0F;
    repeat (4) step();
    check("alt_first_dm", {31'd0, m_sel}, 32'd1);
    repeat (5) step();
    check("alt_second_if", {31'd0, m_sel}, 32'd0);
    repeat (4) step();

    rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0;
    rst0 = 1'b0;

    for (int i = 0; i < 200 && !w1_done; i++) @(posedge clk);
    if (!w1_done) check("w1_timeout", 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // WAIT_CYCLES=1: one ACCESS cycle, ready next, next request sampled the cycle after.
  initial begin
    ifc1.if_req = 0; ifc1.if_addr = '0; ifc1.dm_req = 0; ifc1.dm_we = 0;
    ifc1.dm_addr = '0; ifc1.dm_wdata = '0; ifc1.bus_rdata = '0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    ifc1.dm_req = 1'b1; ifc1.dm_addr = 32'h80; ifc1.bus_rdata = 32'h5A5A_0001;
    @(negedge clk);                              // cycle 0
    check("w1_c0_en", ifc1.bus_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);                              // cycle 1
    check("w1_c1_en",   ifc1.bus_en,   1'b1);
    check("w1_c1_sel",  ifc1.bus_sel,  1'b1);
    check("w1_c1_addr", ifc1.bus_addr, 32'h80);
    check("w1_c1_rdy",  ifc1.dm_ready, 1'b0);
    @(posedge clk); #1;
    ifc1.if_req = 1'b1; ifc1.if_addr = 32'h84; ifc1.bus_rdata = 32'hFFFF_0000;
    @(negedge clk);                              // cycle 2
    check("w1_c2_en",    ifc1.bus_en,   1'b0);
    check("w1_c2_rdy",   ifc1.dm_ready, 1'b1);
    check("w1_c2_rdata", ifc1.dm_rdata, 32'h5A5A_0001);
    @(posedge clk); #1;
    ifc1.dm_req = 1'b0;
    @(negedge clk);                              // cycle 3
    check("w1_c3_en",  ifc1.bus_en,   1'b0);
    check("w1_c3_rdy", ifc1.dm_ready, 1'b0);
    @(posedge clk); #1;
    ifc1.bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);                              // cycle 4
    check("w1_c4_en",   ifc1.bus_en,   1'b1);
    check("w1_c4_sel",  ifc1.bus_sel,  1'b0);
    check("w1_c4_addr", ifc1.bus_addr, 32'h84);
    @(posedge clk); #1;
    @(negedge clk);                              // cycle 5
    check("w1_c5_rdy",   ifc1.if_ready, 1'b1);
    check("w1_c5_rdata", ifc1.if_rdata, 32'h0BAD_F00D);
    check("w1_c5_en",    ifc1.bus_en,   1'b0);
    @(posedge clk); #1;
    ifc1.if_req = 1'b0;
    @(negedge clk);                              // cycle 6
    check("w1_c6_en",  ifc1.bus_en,   1'b0);
    check("w1_c6_rdy", ifc1.if_ready, 1'b0);
    w1_done = 1'b1;
  end
endmodule
